// File: rtl/fp16_pkg.sv
// Shared FP16 constants, FSM state and operand class types
// for the sequential half-precision divider.
package fp16_pkg;

  localparam int EXP_BIAS = 15;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    PACK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

endpackage

// File: rtl/fp16_unpack.sv
// FP16 operand classifier: flushes subnormals to zero and
// inserts the hidden bit into the 11-bit significand.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]       x,
  output fp_class_t         cls,
  output logic              sign,
  output logic [EXP_W-1:0]  expn,
  output logic [FRAC_W:0]   man
);

  always_comb begin
    sign = x[15];
    expn = x[14:10];
    man  = {1'b1, x[9:0]};
    cls  = NORM;
    unique case (1'b1)
      (x[14:10] == 5'd0): begin
        cls = ZERO;
        man = '0;
      end
      (x[14:10] == 5'h1F && x[9:0] == 10'd0):
        cls = INF;
      (x[14:10] == 5'h1F && x[9:0] != 10'd0):
        cls = NAN;
      default:
        cls = NORM;
    endcase
  end

endmodule

// File: rtl/fp16_divider_seq.sv
// Radix-2 restoring FP16 divider, one quotient bit per cycle.
// ROUND_NEAREST_EN selects round-to-nearest-even; else truncate.
module fp16_divider_seq
  import fp16_pkg::*;
#(
  parameter int GUARD_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
);

  localparam int N     = FRAC_W + 1 + GUARD_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t state, state_nx;

  logic [15:0]        a_r, b_r;
  logic               sign_r;
  logic signed [6:0]  exp_r;
  logic [FRAC_W:0]    mb_r;
  logic [FRAC_W+1:0]  rem_r;
  logic [N-1:0]       q_r;
  logic [CNT_W-1:0]   cnt;
  logic               spec_r;
  logic [15:0]        spec_res_r;

  fp_class_t          ca, cb;
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [FRAC_W:0]    ma, mb;

  fp16_unpack u_a (.x(a_r), .cls(ca), .sign(sa), .expn(ea), .man(ma));
  fp16_unpack u_b (.x(b_r), .cls(cb), .sign(sb), .expn(eb), .man(mb));

  logic              s;
  logic              spec;
  logic [15:0]       spec_res;
  logic signed [6:0] exp_pre;
  logic              lt;

  assign s       = sa ^ sb;
  assign exp_pre = {2'b00, ea} - {2'b00, eb} + 7'(EXP_BIAS);
  assign lt      = ma < mb;

  always_comb begin
    spec     = 1'b1;
    spec_res = QNAN;
    if (ca == NAN || cb == NAN)
      spec_res = QNAN;
    else if ((ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
      spec_res = QNAN;
    else if (ca == INF || cb == ZERO)
      spec_res = {s, POS_INF[14:0]};
    else if (ca == ZERO || cb == INF)
      spec_res = {s, 15'h0000};
    else
      spec = 1'b0;
  end

  // Quotient MSB is always 1; fraction sits just below it.
  logic [FRAC_W-1:0] frac_t;
  logic              rnd;
  logic              unused;

  assign frac_t = q_r[N-2 -: FRAC_W];

`ifdef ROUND_NEAREST_EN
  localparam logic [N-1:0] LOW_MASK = {N{1'b1}} >> (N - GUARD_BITS + 1);
  logic g, lower, sticky;
  assign g      = q_r[GUARD_BITS-1];
  assign lower  = |(q_r & LOW_MASK);
  assign sticky = |rem_r;
  assign rnd    = g & (lower | sticky | frac_t[0]);
  assign unused = q_r[N-1];
`else
  assign rnd    = 1'b0;
  assign unused = ^{q_r[N-1], q_r[GUARD_BITS-1:0]};
`endif

  logic [FRAC_W:0]   fsum;
  logic signed [6:0] exp_f;
  logic [15:0]       pack_res;

  assign fsum  = {1'b0, frac_t} + {{FRAC_W{1'b0}}, rnd};
  assign exp_f = exp_r + {6'b0, fsum[FRAC_W]};

  always_comb begin
    if (spec_r)
      pack_res = spec_res_r;
    else if (exp_f <= 7'sd0)
      pack_res = {sign_r, 15'h0000};
    else if (exp_f >= 7'sd31)
      pack_res = {sign_r, POS_INF[14:0]};
    else
      pack_res = {sign_r, exp_f[4:0], fsum[FRAC_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = PREP;
      PREP: state_nx = spec ? PACK : DIV;
      DIV:  if (cnt == LAST) state_nx = PACK;
      PACK: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      mb_r       <= '0;
      rem_r      <= '0;
      q_r        <= '0;
      cnt        <= '0;
      spec_r     <= 1'b0;
      spec_res_r <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
        end
        PREP: begin
          sign_r     <= s;
          spec_r     <= spec;
          spec_res_r <= spec_res;
          mb_r       <= mb;
          q_r        <= '0;
          cnt        <= '0;
          rem_r      <= lt ? {ma, 1'b0} : {1'b0, ma};
          exp_r      <= lt ? exp_pre - 7'sd1 : exp_pre;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (rem_r >= {1'b0, mb_r}) begin
            q_r   <= {q_r[N-2:0], 1'b1};
            rem_r <= (rem_r - {1'b0, mb_r}) << 1;
          end else begin
            q_r   <= {q_r[N-2:0], 1'b0};
            rem_r <= rem_r << 1;
          end
        end
        PACK: result <= pack_res;
        default: ;
      endcase
    end
  end

endmodule
